// File: rtl/gba_io_pkg.sv
// Shared types and helpers for the GBA cartridge bus frontend.
// Holds the FSM state enum, width codes and address builders.
package gba_io_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROM_IDLE,
      ROM_RD_WAIT,
      ROM_RD_HOLD,
      SRAM_IDLE,
      SRAM_RD_WAIT,
      SRAM_RD_HOLD
   } fe_state_e;

   localparam logic [1:0] WIDTH_CS1 = 2'b10;
   localparam logic [1:0] WIDTH_CS2 = 2'b01;

   // ROM halfword address -> byte address in the low half of the map
   function automatic logic [25:0] cs1_addr(
      input logic [7:0]  ahi,
      input logic [15:0] alo
   );
      return {1'b0, ahi, alo, 1'b0};
   endfunction

   // SRAM byte address sits in the upper half of the map
   function automatic logic [25:0] cs2_addr(
      input logic [15:0] ad
   );
      return {1'b1, 9'b0, ad};
   endfunction

endpackage

// File: rtl/gba_cart_bus_frontend_if.sv
// Request/response bundle between the GBA frontend and the cart mux.
// cart: frontend side (issues requests); mux: responder side.
interface cart_mux_interface;

   logic        cart_rd;
   logic        cart_wr;
   logic [25:0] cart_addr;
   logic [1:0]  cart_data_width;
   logic [15:0] cart_wr_data;
   logic        cart_rd_valid;
   logic [15:0] cart_rd_data;

   modport cart (
      output cart_rd, cart_wr, cart_addr,
      output cart_data_width, cart_wr_data,
      input  cart_rd_valid, cart_rd_data
   );

   modport mux (
      input  cart_rd, cart_wr, cart_addr,
      input  cart_data_width, cart_wr_data,
      output cart_rd_valid, cart_rd_data
   );

endinterface

// File: rtl/gba_pin_sync.sv
// N-stage synchroniser for one GBA pin with a registered edge strobe.
// Ports: d (raw pin), q (synchronised level), edge_o (1-cycle toggle).
module gba_pin_sync #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic edge_o
);

   logic [N-1:0] s;

   // edge_o rises together with the new q level, so
   // fall = edge_o & ~q and rise = edge_o & q downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s      <= {N{RST_VAL}};
         edge_o <= 1'b0;
      end else begin
         s      <= {s[N-2:0], d};
         edge_o <= s[N-1] ^ s[N-2];
      end
   end

   assign q = s[N-1];

endmodule

// File: rtl/gba_cart_bus_frontend.sv
// Converts raw GBA cartridge pins (ROM cs/AD bus, SRAM cs2 bus) into
// single-cycle cart_rd/cart_wr requests and drives read data back.
// Ports: clk, rst, gba_* pins (in/out/oe), cart (mux requests),
// bus_err (sticky illegal access), rd_timeout (1-cycle pulse).
module gba_cart_bus_frontend
   import gba_io_pkg::*;
#(
   parameter int          SYNC_STAGES  = 2,
   parameter int          RD_TIMEOUT   = 64,
   parameter logic [15:0] TIMEOUT_DATA = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gba_cs_n,
   input  logic        gba_cs2_n,
   input  logic        gba_rd_n,
   input  logic        gba_wr_n,
   input  logic [15:0] gba_ad_i,
   output logic [15:0] gba_ad_o,
   output logic        gba_ad_oe,
   input  logic [7:0]  gba_a_i,
   output logic [7:0]  gba_a_o,
   output logic        gba_a_oe,
   cart_mux_interface.cart cart,
   output logic        bus_err,
   output logic        rd_timeout
);

   localparam int CW = $clog2(RD_TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(RD_TIMEOUT - 1);

   logic cs_s, cs2_s, rd_s, wr_s;
   logic cs_e, cs2_e, rd_e, wr_e;

   gba_pin_sync #(.N(SYNC_STAGES)) u_cs (
      .clk, .rst, .d(gba_cs_n), .q(cs_s), .edge_o(cs_e));
   gba_pin_sync #(.N(SYNC_STAGES)) u_cs2 (
      .clk, .rst, .d(gba_cs2_n), .q(cs2_s), .edge_o(cs2_e));
   gba_pin_sync #(.N(SYNC_STAGES)) u_rd (
      .clk, .rst, .d(gba_rd_n), .q(rd_s), .edge_o(rd_e));
   gba_pin_sync #(.N(SYNC_STAGES)) u_wr (
      .clk, .rst, .d(gba_wr_n), .q(wr_s), .edge_o(wr_e));

   logic [SYNC_STAGES-1:0][15:0] ad_s;
   logic [SYNC_STAGES-1:0][7:0]  a_s;
   logic [15:0] ad_q;
   logic [7:0]  a_q;

   // Data buses share the strobe depth so they line up with the edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ad_s <= '0;
         a_s  <= '0;
      end else begin
         ad_s <= {ad_s[SYNC_STAGES-2:0], gba_ad_i};
         a_s  <= {a_s[SYNC_STAGES-2:0], gba_a_i};
      end
   end

   assign ad_q = ad_s[SYNC_STAGES-1];
   assign a_q  = a_s[SYNC_STAGES-1];

   logic cs_fall, cs_rise, cs2_fall, cs2_rise;
   logic rd_fall, rd_rise, wr_rise;

   assign cs_fall  = cs_e & ~cs_s;
   assign cs_rise  = cs_e & cs_s;
   assign cs2_fall = cs2_e & ~cs2_s;
   assign cs2_rise = cs2_e & cs2_s;
   assign rd_fall  = rd_e & ~rd_s;
   assign rd_rise  = rd_e & rd_s;
   assign wr_rise  = wr_e & wr_s;

   fe_state_e   state_q, state_d;
   logic [7:0]  ahi_q, ahi_d;
   logic [15:0] alo_q, alo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        req_rd_q, req_rd_d;
   logic        req_wr_q, req_wr_d;
   logic [25:0] addr_q, addr_d;
   logic [1:0]  width_q, width_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] ad_o_q, ad_o_d;
   logic [7:0]  a_o_q, a_o_d;
   logic        ad_oe_q, ad_oe_d;
   logic        a_oe_q, a_oe_d;
   logic        err_q, err_d;
   logic        tmo_q, tmo_d;
   logic        abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ahi_q    <= '0;
         alo_q    <= '0;
         cnt_q    <= '0;
         req_rd_q <= 1'b0;
         req_wr_q <= 1'b0;
         addr_q   <= '0;
         width_q  <= 2'b00;
         wdata_q  <= '0;
         ad_o_q   <= '0;
         a_o_q    <= '0;
         ad_oe_q  <= 1'b0;
         a_oe_q   <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ahi_q    <= ahi_d;
         alo_q    <= alo_d;
         cnt_q    <= cnt_d;
         req_rd_q <= req_rd_d;
         req_wr_q <= req_wr_d;
         addr_q   <= addr_d;
         width_q  <= width_d;
         wdata_q  <= wdata_d;
         ad_o_q   <= ad_o_d;
         a_o_q    <= a_o_d;
         ad_oe_q  <= ad_oe_d;
         a_oe_q   <= a_oe_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   // A deselect aborts any access; responses arriving later land in a
   // state that does not look at cart_rd_valid and are dropped.
   assign abort = (state_q != IDLE) & (cs_rise | cs2_rise);

   always_comb begin
      state_d  = state_q;
      ahi_d    = ahi_q;
      alo_d    = alo_q;
      cnt_d    = cnt_q;
      req_rd_d = 1'b0;
      req_wr_d = 1'b0;
      addr_d   = addr_q;
      width_d  = width_q;
      wdata_d  = wdata_q;
      ad_o_d   = ad_o_q;
      a_o_d    = a_o_q;
      ad_oe_d  = ad_oe_q;
      a_oe_d   = a_oe_q;
      err_d    = err_q | (~cs_s & ~cs2_s);
      tmo_d    = 1'b0;
      if (abort) begin
         state_d = IDLE;
         ad_oe_d = 1'b0;
         a_oe_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall & cs2_s) begin
                  ahi_d   = a_q;
                  alo_d   = ad_q;
                  state_d = ROM_IDLE;
               end else if (cs2_fall & cs_s) begin
                  state_d = SRAM_IDLE;
               end
            end
            ROM_IDLE: begin
               if (rd_fall) begin
                  req_rd_d = 1'b1;
                  addr_d   = cs1_addr(ahi_q, alo_q);
                  width_d  = WIDTH_CS1;
                  ad_oe_d  = 1'b1;
                  cnt_d    = '0;
                  err_d    = err_d | wr_rise;
                  state_d  = ROM_RD_WAIT;
               end else if (wr_rise) begin
                  req_wr_d = 1'b1;
                  addr_d   = cs1_addr(ahi_q, alo_q);
                  width_d  = WIDTH_CS1;
                  wdata_d  = ad_q;
                  alo_d    = alo_q + 16'd1;
               end
            end
            ROM_RD_WAIT: begin
               if (cart.cart_rd_valid) begin
                  ad_o_d  = cart.cart_rd_data;
                  state_d = ROM_RD_HOLD;
               end else if (cnt_q == LAST) begin
                  ad_o_d  = TIMEOUT_DATA;
                  tmo_d   = 1'b1;
                  state_d = ROM_RD_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ROM_RD_HOLD: begin
               if (rd_rise) begin
                  ad_oe_d = 1'b0;
                  alo_d   = alo_q + 16'd1;
                  state_d = ROM_IDLE;
               end
            end
            SRAM_IDLE: begin
               if (rd_fall) begin
                  req_rd_d = 1'b1;
                  addr_d   = cs2_addr(ad_q);
                  width_d  = WIDTH_CS2;
                  a_oe_d   = 1'b1;
                  cnt_d    = '0;
                  err_d    = err_d | wr_rise;
                  state_d  = SRAM_RD_WAIT;
               end else if (wr_rise) begin
                  req_wr_d = 1'b1;
                  addr_d   = cs2_addr(ad_q);
                  width_d  = WIDTH_CS2;
                  wdata_d  = {8'h00, a_q};
               end
            end
            SRAM_RD_WAIT: begin
               if (cart.cart_rd_valid) begin
                  a_o_d   = cart.cart_rd_data[7:0];
                  state_d = SRAM_RD_HOLD;
               end else if (cnt_q == LAST) begin
                  a_o_d   = TIMEOUT_DATA[7:0];
                  tmo_d   = 1'b1;
                  state_d = SRAM_RD_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            SRAM_RD_HOLD: begin
               if (rd_rise) begin
                  a_oe_d  = 1'b0;
                  state_d = SRAM_IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign cart.cart_rd         = req_rd_q;
   assign cart.cart_wr         = req_wr_q;
   assign cart.cart_addr       = addr_q;
   assign cart.cart_data_width = width_q;
   assign cart.cart_wr_data    = wdata_q;
   assign gba_ad_o             = ad_o_q;
   assign gba_ad_oe            = ad_oe_q;
   assign gba_a_o              = a_o_q;
   assign gba_a_oe             = a_oe_q;
   assign bus_err              = err_q;
   assign rd_timeout           = tmo_q;

endmodule

// File: tb/tb_gba_cart_bus_frontend.sv
// Self-checking bench for gba_cart_bus_frontend.
// Drives GBA pin sequences and acts as the cart mux responder.
module tb_gba_cart_bus_frontend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gba_cs_n = 1'b1;
   logic        gba_cs2_n = 1'b1;
   logic        gba_rd_n = 1'b1;
   logic        gba_wr_n = 1'b1;
   logic [15:0] gba_ad_i = '0;
   logic [15:0] gba_ad_o;
   logic        gba_ad_oe;
   logic [7:0]  gba_a_i = '0;
   logic [7:0]  gba_a_o;
   logic        gba_a_oe;
   logic        bus_err;
   logic        rd_timeout;

   int n_chk = 0;
   int n_fail = 0;
   int n_rd = 0, n_wr = 0, n_both = 0, n_wide = 0, n_tmo = 0;
   bit prev_rd = 0, prev_wr = 0;

   cart_mux_interface mif ();

   gba_cart_bus_frontend dut (
      .clk       (clk),
      .rst       (rst),
      .gba_cs_n  (gba_cs_n),
      .gba_cs2_n (gba_cs2_n),
      .gba_rd_n  (gba_rd_n),
      .gba_wr_n  (gba_wr_n),
      .gba_ad_i  (gba_ad_i),
      .gba_ad_o  (gba_ad_o),
      .gba_ad_oe (gba_ad_oe),
      .gba_a_i   (gba_a_i),
      .gba_a_o   (gba_a_o),
      .gba_a_oe  (gba_a_oe),
      .cart      (mif.cart),
      .bus_err   (bus_err),
      .rd_timeout(rd_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mif.cart_rd) n_rd++;
      if (mif.cart_wr) n_wr++;
      if (mif.cart_rd && mif.cart_wr) n_both++;
      if ((mif.cart_rd && prev_rd) || (mif.cart_wr && prev_wr)) n_wide++;
      if (rd_timeout) n_tmo++;
      prev_rd = mif.cart_rd;
      prev_wr = mif.cart_wr;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference byte address of a ROM halfword access
   function automatic logic [25:0] rom_ref(input int hi, input int lo);
      return 26'((hi * 65536 + lo) * 2);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      gba_cs_n = 1'b1; gba_cs2_n = 1'b1;
      gba_rd_n = 1'b1; gba_wr_n = 1'b1;
      mif.cart_rd_valid = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic wait_req(output bit got, output int lat,
                           output bit w, output logic [25:0] a,
                           output logic [1:0] wd, output logic [15:0] d);
      got = 0; lat = 0; w = 0; a = '0; wd = '0; d = '0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (mif.cart_rd || mif.cart_wr) begin
            got = 1; lat = i; w = mif.cart_wr;
            a = mif.cart_addr; wd = mif.cart_data_width;
            d = mif.cart_wr_data;
            return;
         end
      end
   endtask

   task automatic mux_respond(input int dly, input logic [15:0] d);
      tick(dly);
      mif.cart_rd_valid = 1'b1;
      mif.cart_rd_data = d;
      tick();
      mif.cart_rd_valid = 1'b0;
      tick();
   endtask

   task automatic rom_open(input logic [7:0] hi, input logic [15:0] lo);
      gba_a_i = hi; gba_ad_i = lo;
      tick();
      gba_cs_n = 1'b0;
      tick(5);
   endtask

   task automatic rom_close();
      gba_rd_n = 1'b1; gba_wr_n = 1'b1;
      gba_cs_n = 1'b1;
      tick(5);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      n_chk++;
      if ({mif.cart_rd, mif.cart_wr, mif.cart_addr, mif.cart_data_width,
           mif.cart_wr_data, gba_ad_oe, gba_a_oe} !== '0) begin
         n_fail++;
         $display("FAIL reset_cart: got %h/%h/%h/%h oe=%b%b want 0",
                  mif.cart_addr, mif.cart_data_width, mif.cart_wr_data,
                  {mif.cart_rd, mif.cart_wr}, gba_ad_oe, gba_a_oe);
      end
      rst = 1'b0;
      tick(3);
      n_chk++;
      if ({gba_ad_o, gba_a_o, bus_err, rd_timeout} !== '0) begin
         n_fail++;
         $display("FAIL reset_pins: got ad_o=%h a_o=%h err=%b tmo=%b want 0",
                  gba_ad_o, gba_a_o, bus_err, rd_timeout);
      end
   endtask

   task automatic test_rom_burst();
      bit got, w; int lat;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d;
      logic [15:0] dat [3] = '{16'hA001, 16'hA002, 16'hA003};
      int lo = 16'h3456;
      rom_open(8'h12, 16'h3456);
      for (int i = 0; i < 3; i++) begin
         gba_ad_i = 16'($urandom);
         gba_rd_n = 1'b0;
         wait_req(got, lat, w, a, wd, d);
         n_chk++;
         if ({got, w, a, wd} !== {2'b10, rom_ref(8'h12, lo), 2'b10}) begin
            n_fail++;
            $display("FAIL rom_burst_req%0d: got=%b w=%b addr=%h wd=%b want addr=%h wd=10",
                     i, got, w, a, wd, rom_ref(8'h12, lo));
         end
         if (i == 0) begin
            n_chk++;
            if (lat !== 3) begin
               n_fail++;
               $display("FAIL rom_latency: got %0d want 3", lat);
            end
         end
         mux_respond(i, dat[i]);
         n_chk++;
         if ({gba_ad_oe, gba_ad_o} !== {1'b1, dat[i]}) begin
            n_fail++;
            $display("FAIL rom_burst_data%0d: got oe=%b %h want 1 %h",
                     i, gba_ad_oe, gba_ad_o, dat[i]);
         end
         gba_rd_n = 1'b1;
         tick(4);
         n_chk++;
         if (gba_ad_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_burst_oe_drop%0d: got %b want 0", i, gba_ad_oe);
         end
         lo = (lo + 1) % 65536;
      end
      rom_close();
   endtask

   task automatic test_wrap();
      bit got, w; int lat;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d;
      int lo = 16'hFFFF;
      rom_open(8'h12, 16'hFFFF);
      for (int i = 0; i < 2; i++) begin
         gba_rd_n = 1'b0;
         wait_req(got, lat, w, a, wd, d);
         n_chk++;
         if ({got, w, a} !== {2'b10, rom_ref(8'h12, lo)}) begin
            n_fail++;
            $display("FAIL wrap_addr%0d: got=%b addr=%h want %h",
                     i, got, a, rom_ref(8'h12, lo));
         end
         mux_respond(1, 16'($urandom));
         gba_rd_n = 1'b1;
         tick(4);
         lo = (lo + 1) % 65536;
      end
      rom_close();
   endtask

   task automatic test_sram();
      bit got, w; int lat;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d;
      gba_cs2_n = 1'b0;
      tick(5);
      gba_ad_i = 16'h0100; gba_a_i = 8'h5A;
      gba_wr_n = 1'b0;
      tick(3);
      gba_wr_n = 1'b1;
      wait_req(got, lat, w, a, wd, d);
      n_chk++;
      if ({got, w, a, wd, d} !== {2'b11, 26'h2000100, 2'b01, 16'h005A}) begin
         n_fail++;
         $display("FAIL sram_wr: got=%b w=%b addr=%h wd=%b d=%h want 2000100 01 005a",
                  got, w, a, wd, d);
      end
      gba_rd_n = 1'b0;
      wait_req(got, lat, w, a, wd, d);
      n_chk++;
      if ({got, w, a, wd, gba_a_oe} !== {2'b10, 26'h2000100, 2'b01, 1'b1}) begin
         n_fail++;
         $display("FAIL sram_rd: got=%b w=%b addr=%h wd=%b oe=%b want 2000100 01 1",
                  got, w, a, wd, gba_a_oe);
      end
      mux_respond(2, 16'h005A);
      n_chk++;
      if ({gba_a_oe, gba_a_o, gba_ad_oe} !== {1'b1, 8'h5A, 1'b0}) begin
         n_fail++;
         $display("FAIL sram_rd_data: got a_oe=%b a_o=%h ad_oe=%b want 1 5a 0",
                  gba_a_oe, gba_a_o, gba_ad_oe);
      end
      gba_rd_n = 1'b1;
      tick(4);
      n_chk++;
      if (gba_a_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL sram_oe_drop: got %b want 0", gba_a_oe);
      end
      gba_cs2_n = 1'b1;
      tick(5);
   endtask

   task automatic test_timeout();
      bit got, w; int lat, k, t0;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d;
      rom_open(8'($urandom), 16'($urandom));
      t0 = n_tmo;
      gba_rd_n = 1'b0;
      wait_req(got, lat, w, a, wd, d);
      k = 0;
      while (k < 100 && rd_timeout !== 1'b1) begin
         tick();
         k++;
      end
      n_chk++;
      if (k !== 64) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d want 64", k);
      end
      tick(3);
      n_chk++;
      if ({gba_ad_o, gba_ad_oe} !== {16'hFFFF, 1'b1} || n_tmo - t0 !== 1) begin
         n_fail++;
         $display("FAIL timeout_data: got %h oe=%b pulses=%0d want ffff 1 1",
                  gba_ad_o, gba_ad_oe, n_tmo - t0);
      end
      rom_close();
   endtask

   task automatic test_abort();
      bit got, w; int lat, r0;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d, prev;
      rom_open(8'h44, 16'h1000);
      prev = gba_ad_o;
      gba_rd_n = 1'b0;
      wait_req(got, lat, w, a, wd, d);
      gba_cs_n = 1'b1;
      tick(4);
      mux_respond(0, 16'h1234);
      n_chk++;
      if ({gba_ad_oe, gba_ad_o} !== {1'b0, prev}) begin
         n_fail++;
         $display("FAIL abort_late_valid: got oe=%b %h want 0 %h",
                  gba_ad_oe, gba_ad_o, prev);
      end
      r0 = n_rd + n_wr;
      gba_rd_n = 1'b1;
      tick(3);
      gba_rd_n = 1'b0;
      tick(6);
      gba_rd_n = 1'b1;
      tick(4);
      n_chk++;
      if (n_rd + n_wr !== r0) begin
         n_fail++;
         $display("FAIL abort_idle: got %0d new requests want 0", n_rd + n_wr - r0);
      end
   endtask

   task automatic test_collision();
      bit got, w; int lat, w0;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d;
      rom_open(8'h21, 16'h0040);
      gba_wr_n = 1'b0;
      tick(4);
      w0 = n_wr;
      gba_rd_n = 1'b0;
      gba_wr_n = 1'b1;
      wait_req(got, lat, w, a, wd, d);
      tick(3);
      n_chk++;
      if ({got, w, a, bus_err} !== {2'b10, rom_ref(8'h21, 16'h0040), 1'b1}
          || n_wr !== w0) begin
         n_fail++;
         $display("FAIL collision: got=%b w=%b addr=%h err=%b wr=%0d want read, err 1, no wr",
                  got, w, a, bus_err, n_wr - w0);
      end
      mux_respond(0, 16'h0BAD);
      rom_close();
      do_reset();
      n_chk++;
      if (bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bus_err_clear: got %b want 0", bus_err);
      end
   endtask

   task automatic test_bus_err();
      int r0;
      gba_cs_n = 1'b0;
      gba_cs2_n = 1'b0;
      tick(6);
      r0 = n_rd + n_wr;
      gba_rd_n = 1'b0; tick(4);
      gba_rd_n = 1'b1; tick(4);
      gba_wr_n = 1'b0; tick(4);
      gba_wr_n = 1'b1; tick(4);
      n_chk++;
      if (bus_err !== 1'b1 || n_rd + n_wr !== r0) begin
         n_fail++;
         $display("FAIL bus_err_both_cs: got err=%b reqs=%0d want 1 0",
                  bus_err, n_rd + n_wr - r0);
      end
      do_reset();
   endtask

   task automatic test_async_reset();
      bit got, w; int lat;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d, dat;
      rom_open(8'h34, 16'h0010);
      gba_rd_n = 1'b0;
      wait_req(got, lat, w, a, wd, d);
      rst = 1'b1;
      #1;
      n_chk++;
      if ({mif.cart_rd, mif.cart_addr, mif.cart_data_width, gba_ad_oe,
           gba_a_oe, gba_ad_o, gba_a_o, bus_err, rd_timeout} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got rd=%b addr=%h wd=%b oe=%b want 0",
                  mif.cart_rd, mif.cart_addr, mif.cart_data_width, gba_ad_oe);
      end
      gba_cs_n = 1'b1; gba_rd_n = 1'b1;
      tick(2);
      rst = 1'b0;
      mux_respond(0, 16'hBEEF);
      n_chk++;
      if ({gba_ad_o, gba_ad_oe} !== '0) begin
         n_fail++;
         $display("FAIL reset_pending_valid: got %h oe=%b want 0 0",
                  gba_ad_o, gba_ad_oe);
      end
      rom_open(8'h56, 16'h789A);
      gba_rd_n = 1'b0;
      wait_req(got, lat, w, a, wd, d);
      dat = 16'($urandom);
      mux_respond(1, dat);
      n_chk++;
      if ({got, w, a, gba_ad_o} !== {2'b10, rom_ref(8'h56, 16'h789A), dat}) begin
         n_fail++;
         $display("FAIL post_reset_rom: got=%b addr=%h data=%h want %h %h",
                  got, a, gba_ad_o, rom_ref(8'h56, 16'h789A), dat);
      end
      rom_close();
   endtask

   task automatic test_random();
      bit got, w; int lat, hi, lo;
      logic [25:0] a; logic [1:0] wd; logic [15:0] d, dat;
      for (int b = 0; b < 4; b++) begin
         hi = int'($urandom_range(0, 255));
         lo = (b == 0) ? 16'hFFFE : int'($urandom_range(0, 65535));
         rom_open(8'(hi), 16'(lo));
         for (int j = 0; j < 4; j++) begin
            dat = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               gba_rd_n = 1'b0;
               wait_req(got, lat, w, a, wd, d);
               mux_respond(int'($urandom_range(0, 6)), dat);
               n_chk++;
               if ({got, w, a, wd, gba_ad_o} !==
                   {2'b10, rom_ref(hi, lo), 2'b10, dat}) begin
                  n_fail++;
                  $display("FAIL rand_rd b%0d j%0d: addr=%h data=%h want %h %h",
                           b, j, a, gba_ad_o, rom_ref(hi, lo), dat);
               end
               gba_rd_n = 1'b1;
               tick(4);
            end else begin
               gba_ad_i = dat;
               gba_wr_n = 1'b0;
               tick(2);
               gba_wr_n = 1'b1;
               wait_req(got, lat, w, a, wd, d);
               n_chk++;
               if ({got, w, a, wd, d} !==
                   {2'b11, rom_ref(hi, lo), 2'b10, dat}) begin
                  n_fail++;
                  $display("FAIL rand_wr b%0d j%0d: addr=%h d=%h want %h %h",
                           b, j, a, d, rom_ref(hi, lo), dat);
               end
               tick(2);
            end
            lo = (lo + 1) % 65536;
         end
         rom_close();
      end
   endtask

   task automatic test_strobe_rules();
      n_chk++;
      if (n_both !== 0 || n_wide !== 0) begin
         n_fail++;
         $display("FAIL strobe_rules: got both=%0d wide=%0d want 0 0",
                  n_both, n_wide);
      end
   endtask

   initial begin
      mif.cart_rd_valid = 1'b0;
      mif.cart_rd_data = '0;
      test_reset();
      test_rom_burst();
      test_wrap();
      test_sram();
      test_timeout();
      test_abort();
      test_random();
      test_collision();
      test_bus_err();
      test_async_reset();
      test_strobe_rules();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gba_cart_bus_frontend.md
Name: gba_cart_bus_frontend

Overview:
- Upstream feeder of the cart/mux path. Converts the raw GBA cartridge pins into single-cycle cart_rd/cart_wr requests on cart_mux_interface (cart modport).
- Pins handled: multiplexed ROM bus (cs_n, cs1) with auto-increment, and the 8-bit SRAM bus (cs2_n).
- Synchronises all pins, tracks the ROM halfword address counter, and drives read data back onto the pins with output enables.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on every GBA input pin (minimum 2).
- RD_TIMEOUT, 64, clk cycles to wait for cart_rd_valid before returning the fallback value.
- TIMEOUT_DATA, 16'hFFFF, value driven when a read times out.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- gba_cs_n  in  1  ROM chip select.
- gba_cs2_n  in  1  SRAM chip select.
- gba_rd_n  in  1  read strobe.
- gba_wr_n  in  1  write strobe.
- gba_ad_i  in  16  AD pins, input side.
- gba_ad_o  out  16  AD pins, output side (ROM read data).
- gba_ad_oe  out  1  AD output enable.
- gba_a_i  in  8  A[23:16] pins, input side.
- gba_a_o  out  8  A[23:16] output side (SRAM read data).
- gba_a_oe  out  1  A[23:16] output enable.
- cart  cart_mux_interface.cart  -  request side toward the mux.
- bus_err  out  1  sticky: cs_n and cs2_n were both low; cleared only by rst.
- rd_timeout  out  1  one-cycle pulse when a read times out.

Behaviour:
- Reset: all outputs 0. cart_rd=cart_wr=0, cart_addr=0, cart_data_width=2'b00, cart_wr_data=0, both oe=0. FSM returns to IDLE.
- Synchroniser flops reset to 1 for the *_n pins and 0 for data pins.
- Edges are detected on the synchronised signals only. "fall"/"rise" means a 1-cycle registered edge strobe.
- FSM states: IDLE, ROM_IDLE, ROM_RD_WAIT, ROM_RD_HOLD, SRAM_IDLE, SRAM_RD_WAIT, SRAM_RD_HOLD.
- IDLE:
  - cs fall with cs2_n high: latch ahi=a_i and alo=ad_i (halfword address), then go to ROM_IDLE.
  - cs2 fall with cs_n high: go to SRAM_IDLE.
  - Both selects low: set bus_err and stay in IDLE.
- ROM_IDLE, rd fall:
  - Pulse cart_rd for 1 cycle.
  - cart_addr = {1'b0, ahi, alo, 1'b0}, cart_data_width = 2'b10.
  - Assert gba_ad_oe the same cycle and go to ROM_RD_WAIT.
- ROM_IDLE, wr rise:
  - Pulse cart_wr with cart_wr_data = synchronised ad_i sampled at that edge, same address and width 2'b10.
  - Then alo += 1.
- ROM_RD_WAIT:
  - On cart_rd_valid: gba_ad_o = cart_rd_data, go to ROM_RD_HOLD.
  - If RD_TIMEOUT cycles pass without valid: gba_ad_o = TIMEOUT_DATA, pulse rd_timeout, go to ROM_RD_HOLD.
- ROM_RD_HOLD, rd rise: drop gba_ad_oe, alo += 1, return to ROM_IDLE.
- Auto-increment arithmetic: alo wraps 16'hFFFF -> 16'h0000 and ahi is never incremented (GBA 128 KiB burst rule).
- SRAM_IDLE, rd fall:
  - Pulse cart_rd with cart_addr = {1'b1, 9'b0, ad_i}, width 2'b01.
  - Assert gba_a_oe and go to SRAM_RD_WAIT.
- SRAM_RD_WAIT: same rules as ROM_RD_WAIT, except gba_a_o = cart_rd_data[7:0] (timeout value TIMEOUT_DATA[7:0]).
- SRAM_RD_HOLD: rd rise drops gba_a_oe and returns to SRAM_IDLE.
- SRAM_IDLE, wr rise: pulse cart_wr with {1'b1, 9'b0, ad_i}, cart_wr_data = {8'h00, a_i}, width 2'b01.
- cs/cs2 rise in any ROM/SRAM state: abort to IDLE the next cycle and drop both oe.
  - A late cart_rd_valid after abort is ignored.
  - An already-issued cart_wr is not retracted.
- Simultaneous rd fall and wr rise in the same cycle: the read is serviced; the write is discarded and bus_err is set.
- Strobe rules: cart_rd and cart_wr are never both high, and each is exactly 1 cycle wide. cart_addr and cart_data_width hold their value until the next request.
- Latency: pin edge to cart_rd/cart_wr is SYNC_STAGES+1 clk cycles.
- Reset mid-access: oe drops immediately (asynchronous). Any pending valid is ignored after reset release.

Decomposition:
- gba_io_pkg contains:
  - frontend FSM state enum.
  - width codes: WIDTH_CS1 = 2'b10, WIDTH_CS2 = 2'b01.
  - address-building helpers for cs1 and cs2.
- Sub-module gba_pin_sync: a parameterised N-stage synchroniser with a registered fall/rise strobe. It is instanced for cs_n, cs2_n, rd_n and wr_n, with a plain bus sync for ad_i and a_i.

Test Plan:
- ROM burst: cs fall with a_i=8'h12, ad_i=16'h3456, then 3 rd pulses with the mux returning 16'hA001/A002/A003.
  -> cart_addr = 26'h0_2468AC, 2468AE, 2468B0, width 2'b10; gba_ad_o follows the returned data; oe high only while rd_n is low.
- Wrap: start with alo=16'hFFFF, 2 reads -> second cart_addr = {1'b0, 8'h12, 16'h0000, 1'b0}; ahi unchanged.
- SRAM write then read: cs2 low, ad_i=16'h0100, a_i=8'h5A, wr pulse -> cart_wr with addr 26'h2000100, data 16'h005A, width 2'b01. A following rd with mux data 16'h005A -> gba_a_o = 8'h5A, gba_a_oe high.
- Timeout: ROM read with no cart_rd_valid -> after 64 cycles rd_timeout pulses once and gba_ad_o = 16'hFFFF.
- Abort/illegal:
  - cs rises during ROM_RD_WAIT, then a late valid arrives -> oe low, FSM in IDLE, gba_ad_o unchanged.
  - cs_n and cs2_n both low -> bus_err = 1 and no requests are issued.
- Async reset asserted mid ROM_RD_WAIT -> all outputs 0 with no clock edge required; the next cs fall starts a clean ROM access.
